freq_calc: RTL and testbench
============================

Name:
freq_calc

Overview:
- Converts one gated measurement result, packed as `{ref_clk_sum, sig_clk_sum}`, into a signal frequency in Hz: `freq = round(sig_sum * REF_CLK_HZ / ref_sum)`.
- Sits directly downstream of the gate/count measurement stage.
- Consumes that stage's one-cycle register-write pulse and 64-bit data, and presents the result through a valid/ready port to the register file / AXI side.
- Arithmetic is iterative: a shift-add multiply followed by a restoring divide. No hard multipliers or dividers are used.

Parameters:
- `REF_CLK_HZ`, default 100_000_000: nominal reference clock frequency in Hz. Must be ≥1 and fit in 32 bits.

Ports:
- `clk_i` in 1: single clock for all logic.
- `rst_i` in 1: synchronous, active-high reset.
- `in_valid_i` in 1: one-cycle pulse; a measurement result is present on `in_data_i`.
- `in_data_i` in 64: `[63:32]` = ref_sum (reference clock count), `[31:0]` = sig_sum (signal edge count).
- `busy_o` out 1: high whenever state ≠ IDLE.
- `drop_cnt_o` out 8: saturating count of `in_valid_i` pulses dropped while busy.
- `out_valid_o` out 1: result available; held until accepted.
- `out_ready_i` in 1: consumer accepts the result when high together with `out_valid_o`.
- `out_freq_o` out 32: frequency in Hz.
- `out_err_o` out 1: ref_sum was zero; result is invalid.
- `out_ovf_o` out 1: quotient exceeded 32 bits; frequency is saturated.

Behaviour:
- Reset, applied on a clock edge while `rst_i`=1, sets:
  - state = IDLE;
  - `busy_o`=0, `out_valid_o`=0, `out_freq_o`=0, `out_err_o`=0, `out_ovf_o`=0, `drop_cnt_o`=0;
  - all datapath registers = 0.
- Reset mid-operation aborts the computation. No result is emitted.

State machine: IDLE → MUL → ROUND → DIV → DONE → IDLE.
- **IDLE:**
  - On `in_valid_i`, capture sig_sum (32b) and ref_sum (32b).
  - If ref_sum==0: go to DONE with `freq`=0xFFFF_FFFF, `err`=1, `ovf`=0.
  - Otherwise go to MUL.
- **MUL (32 cycles):**
  - Shift-add of sig_sum × `REF_CLK_HZ` into a 64-bit product.
  - One multiplier bit per cycle, LSB first.
- **ROUND (1 cycle):**
  - dividend = product + (ref_sum >> 1). The dividend is 65 bits wide, so this addition cannot wrap.
- **DIV (65 cycles):**
  - Restoring divide of the 65-bit dividend by the 32-bit ref_sum, one quotient bit per cycle, MSB first.
  - The quotient is 65 bits wide.
- **Result of DIV:**
  - If quotient[64:32] ≠ 0: `freq`=0xFFFF_FFFF and `ovf`=1.
  - Otherwise `freq`=quotient[31:0] and `ovf`=0.
  - `err`=0 in both cases.
- **DONE:**
  - `out_valid_o`=1. `out_freq_o`, `out_err_o` and `out_ovf_o` are stable while valid.
  - On `out_ready_i`=1: clear `out_valid_o` on that edge and return to IDLE.
  - A new input is accepted no earlier than the following cycle.
  - If `out_ready_i` is high on the first DONE cycle, valid is high for exactly one cycle.

Latency and input handling:
- `in_valid_i` sampled in IDLE at edge N with nonzero ref_sum → `out_valid_o` first high after edge N+99 (1 + 32 + 1 + 65).
- With ref_sum==0 → `out_valid_o` first high after edge N+1.
- `in_valid_i` while state ≠ IDLE (including DONE) is ignored, and `drop_cnt_o` increments, saturating at 255. This counter is cleared only by reset.
- Input is sampled only on a cycle where `in_valid_i`=1. `in_data_i` is don't-care otherwise.
- Width rules:
  - All arithmetic is unsigned.
  - The product never exceeds 64 bits (32 × 32).
  - sig_sum=0 gives freq=0 with no flags set.

Test Plan:
- `REF_CLK_HZ`=100_000_000, in_data={100000, 1000}, `out_ready_i`=1 → `out_valid_o` high at N+99 for 1 cycle, freq=1_000_000, err=0, ovf=0.
- Rounding, with `REF_CLK_HZ`=100:
  - {3, 1} → freq=33.
  - {3, 2} → freq=67.
  - {4, 1} → freq=25 (exact).
  - {2, 1} → freq=50.
- Divide-by-zero: {0, 500} → valid at N+1, freq=0xFFFF_FFFF, err=1, ovf=0. Then {1, 0} → freq=0, no flags.
- Overflow: `REF_CLK_HZ`=100_000_000, {1, 0xFFFF_FFFF} → freq=0xFFFF_FFFF, ovf=1, err=0.
- Backpressure and drops:
  - Hold `out_ready_i`=0 for 20 cycles after valid; pulse `in_valid_i` twice during MUL and once during DONE.
  - Required: result stable, `drop_cnt_o`=3, `busy_o`=1 throughout.
  - After ready, `busy_o`=0 within 1 cycle.
  - Also drive 300 dropped pulses → `drop_cnt_o`=255.
- Reset mid-DIV: assert `rst_i` at N+60 for 1 cycle → next cycle `busy_o`=0, `out_valid_o` stays 0. A fresh input afterwards yields a correct result at +99.

Source files
------------

// File: rtl/freq_calc.sv
// Converts a gated {ref_sum, sig_sum} measurement into a frequency in Hz:
// round(sig_sum * REF_CLK_HZ / ref_sum), using a serial shift-add multiply and a restoring divide.
module freq_calc #(
  parameter int unsigned REF_CLK_HZ = 100_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic [63:0] in_data_i,
  output logic        busy_o,
  output logic [7:0]  drop_cnt_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_freq_o,
  output logic        out_err_o,
  output logic        out_ovf_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_DIV   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [31:0] HZ = REF_CLK_HZ[31:0];

  logic [2:0]  state;
  logic [6:0]  cnt;
  logic [31:0] ref_q;
  logic        zero_q;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] prod;
  logic [64:0] dvd;   // dividend on entry, shifts into quotient as bits retire
  logic [32:0] rem;

  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [32:0] rem_sub;

  assign rem_sh  = {rem[31:0], dvd[64]};
  assign rem_ge  = (rem_sh >= {1'b0, ref_q});
  assign rem_sub = rem_sh - {1'b0, ref_q};
  assign busy_o  = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ref_q       <= '0;
      zero_q      <= 1'b0;
      mcand       <= '0;
      mplier      <= '0;
      prod        <= '0;
      dvd         <= '0;
      rem         <= '0;
      drop_cnt_o  <= '0;
      out_valid_o <= 1'b0;
      out_freq_o  <= '0;
      out_err_o   <= 1'b0;
      out_ovf_o   <= 1'b0;
    end else begin
      if (in_valid_i && (state != S_IDLE) && (drop_cnt_o != 8'hFF))
        drop_cnt_o <= drop_cnt_o + 8'd1;

      case (state)
        S_IDLE: begin
          if (in_valid_i) begin
            ref_q  <= in_data_i[63:32];
            mcand  <= {32'd0, in_data_i[31:0]};
            mplier <= HZ;
            prod   <= '0;
            cnt    <= '0;
            zero_q <= (in_data_i[63:32] == 32'd0);
            state  <= (in_data_i[63:32] == 32'd0) ? S_DONE : S_MUL;
          end
        end

        S_MUL: begin
          if (mplier[0])
            prod <= prod + mcand;
          mcand  <= {mcand[62:0], 1'b0};
          mplier <= {1'b0, mplier[31:1]};
          cnt    <= cnt + 7'd1;
          if (cnt == 7'd31)
            state <= S_ROUND;
        end

        S_ROUND: begin
          // Half-divisor bias turns the truncating divide into round-half-up.
          dvd   <= {1'b0, prod} + {33'd0, 1'b0, ref_q[31:1]};
          rem   <= '0;
          cnt   <= '0;
          state <= S_DIV;
        end

        S_DIV: begin
          rem   <= rem_ge ? rem_sub : rem_sh;
          dvd   <= {dvd[63:0], rem_ge};
          cnt   <= cnt + 7'd1;
          if (cnt == 7'd64)
            state <= S_DONE;
        end

        S_DONE: begin
          // First DONE cycle formats the result; ready only matters once valid is up.
          if (!out_valid_o) begin
            out_valid_o <= 1'b1;
            if (zero_q) begin
              out_freq_o <= 32'hFFFF_FFFF;
              out_err_o  <= 1'b1;
              out_ovf_o  <= 1'b0;
            end else if (dvd[64:32] != 33'd0) begin
              out_freq_o <= 32'hFFFF_FFFF;
              out_err_o  <= 1'b0;
              out_ovf_o  <= 1'b1;
            end else begin
              out_freq_o <= dvd[31:0];
              out_err_o  <= 1'b0;
              out_ovf_o  <= 1'b0;
            end
          end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_calc.sv
// Directed scoreboard bench for freq_calc: two instances (100 MHz and 100 Hz reference)
// driven sequentially; expected results come from a direct wide-arithmetic model.
module tb_freq_calc;

  typedef struct {
    logic [31:0] freq;
    logic        err;
    logic        ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic [1:0]       rst;
  logic [1:0]       in_valid;
  logic [1:0][63:0] in_data;
  logic [1:0]       busy;
  logic [1:0][7:0]  drop_cnt;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0][31:0] out_freq;
  logic [1:0]       out_err;
  logic [1:0]       out_ovf;

  int   checks = 0;
  int   errors = 0;
  int   exp_drop [2];
  exp_t sbq [$];

  always #5 clk = ~clk;

  freq_calc #(.REF_CLK_HZ(100_000_000)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .in_valid_i(in_valid[0]), .in_data_i(in_data[0]),
    .busy_o(busy[0]), .drop_cnt_o(drop_cnt[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .out_freq_o(out_freq[0]), .out_err_o(out_err[0]),
    .out_ovf_o(out_ovf[0])
  );

  freq_calc #(.REF_CLK_HZ(100)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .in_valid_i(in_valid[1]), .in_data_i(in_data[1]),
    .busy_o(busy[1]), .drop_cnt_o(drop_cnt[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .out_freq_o(out_freq[1]), .out_err_o(out_err[1]),
    .out_ovf_o(out_ovf[1])
  );

  function automatic logic [31:0] hz_of(input int sel);
    return (sel == 0) ? 32'd100_000_000 : 32'd100;
  endfunction

  function automatic exp_t model(input logic [31:0] r, input logic [31:0] s, input logic [31:0] hz);
    exp_t e;
    logic [95:0] q;
    if (r == 32'd0) begin
      e.freq = 32'hFFFF_FFFF; e.err = 1'b1; e.ovf = 1'b0;
    end else begin
      q = (96'(s) * 96'(hz) + 96'(r >> 1)) / 96'(r);
      e.err  = 1'b0;
      e.ovf  = (q > 96'h0FFFF_FFFF);
      e.freq = e.ovf ? 32'hFFFF_FFFF : q[31:0];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input int sel, input logic [31:0] r, input logic [31:0] s);
    @(negedge clk);
    in_valid[sel] = 1'b1;
    in_data[sel]  = {r, s};
    sbq.push_back(model(r, s, hz_of(sel)));
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    in_data[sel]  = {$urandom, $urandom};
  endtask

  task automatic wait_valid(input int sel, input int exp_lat);
    int lat;
    lat = 201;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid[sel]) begin
        lat = k;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_pop(input int sel);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sbq.pop_front();
    chk("freq", 64'(out_freq[sel]), 64'(e.freq));
    chk("err",  64'(out_err[sel]),  64'(e.err));
    chk("ovf",  64'(out_ovf[sel]),  64'(e.ovf));
  endtask

  task automatic accept(input int sel);
    @(posedge clk);
    @(negedge clk);
    chk("valid_after_accept", 64'(out_valid[sel]), 64'd0);
    chk("busy_after_accept",  64'(busy[sel]),      64'd0);
  endtask

  task automatic run(input int sel, input logic [31:0] r, input logic [31:0] s, input int lat);
    send(sel, r, s);
    wait_valid(sel, lat);
    check_pop(sel);
    accept(sel);
  endtask

  initial begin
    int   lat;
    logic seen;
    exp_t e;

    rst       = 2'b11;
    in_valid  = 2'b00;
    in_data   = '0;
    out_ready = 2'b11;
    exp_drop[0] = 0;
    exp_drop[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy",  64'(busy[d]),      64'd0);
      chk("rst_valid", 64'(out_valid[d]), 64'd0);
      chk("rst_freq",  64'(out_freq[d]),  64'd0);
      chk("rst_err",   64'(out_err[d]),   64'd0);
      chk("rst_ovf",   64'(out_ovf[d]),   64'd0);
      chk("rst_drop",  64'(drop_cnt[d]),  64'd0);
    end
    rst = 2'b00;

    // Backpressure: two drops during MUL, one during a held DONE.
    out_ready[0] = 1'b0;
    send(0, 32'd100000, 32'd1000);
    lat = 201;
    for (int k = 1; k <= 200; k++) begin
      in_valid[0] = (k == 5 || k == 10);
      in_data[0]  = {$urandom, $urandom};
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      @(negedge clk);
      chk("bp_busy_compute", 64'(busy[0]), 64'd1);
      if (out_valid[0]) begin
        lat = k;
        break;
      end
    end
    chk("bp_latency", 64'(lat), 64'd99);
    exp_drop[0] += 2;
    e = sbq[0];
    for (int j = 1; j <= 20; j++) begin
      in_valid[0] = (j == 3);
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      @(negedge clk);
      chk("bp_valid_held", 64'(out_valid[0]), 64'd1);
      chk("bp_freq_stable", 64'(out_freq[0]), 64'(e.freq));
      chk("bp_busy_done", 64'(busy[0]), 64'd1);
    end
    exp_drop[0] += 1;
    chk("bp_drop_cnt", 64'(drop_cnt[0]), 64'(exp_drop[0]));
    check_pop(0);
    out_ready[0] = 1'b1;
    accept(0);

    run(0, 32'd100000, 32'd1000, 99);
    run(0, 32'd0, 32'd500, 1);
    run(0, 32'd1, 32'd0, 99);
    run(0, 32'd1, 32'hFFFF_FFFF, 99);
    run(0, 32'd7, 32'd123456, 99);
    chk("drop_unchanged", 64'(drop_cnt[0]), 64'(exp_drop[0]));

    // Rounding on the 100 Hz instance.
    run(1, 32'd3, 32'd1, 99);
    run(1, 32'd3, 32'd2, 99);
    run(1, 32'd4, 32'd1, 99);
    run(1, 32'd2, 32'd1, 99);

    // Saturating drop counter while a result is held.
    out_ready[1] = 1'b0;
    send(1, 32'd3, 32'd1);
    for (int i = 0; i < 300; i++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid[1] = 1'b0;
    exp_drop[1] = (exp_drop[1] + 300 > 255) ? 255 : exp_drop[1] + 300;
    @(negedge clk);
    chk("drop_saturate", 64'(drop_cnt[1]), 64'(exp_drop[1]));
    chk("sat_valid", 64'(out_valid[1]), 64'd1);
    check_pop(1);
    out_ready[1] = 1'b1;
    accept(1);

    // Reset mid-DIV aborts the computation.
    send(1, 32'd4, 32'd1);
    repeat (59) @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    exp_drop[1] = 0;
    sbq.delete();
    chk("midrst_busy",  64'(busy[1]),      64'd0);
    chk("midrst_valid", 64'(out_valid[1]), 64'd0);
    chk("midrst_drop",  64'(drop_cnt[1]),  64'd0);
    seen = 1'b0;
    repeat (110) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | out_valid[1];
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    run(1, 32'd2, 32'd1, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
